alu_pipe: RTL and testbench

//  Parametrised multi-op ALU with a STAGES-deep valid/ready pipeline and a status-flag output.

---
 rtl/alu_pipe.sv | 129 ++++++++++++
 tb/tb_alu_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pipe : multi-op ALU feeding a STAGES-deep valid/ready pipeline with     |
// |            {C,V,N,Z} status flags and bubble-collapsing backpressure.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [2:0]       i_OP,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_Y,
  output logic [3:0]       o_FLAGS
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] alu_y_d;
  logic             w_c;
  logic             w_v;
  logic [3:0]       alu_flags_d;

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit (and is naturally 0 for a zero shift amount).
  always_comb begin
    w_sum = {1'b0, i_A} + {1'b0, i_B};
    w_dif = {1'b0, i_A} - {1'b0, i_B};
    w_amt = i_B[SHW-1:0];
    w_shl = {1'b0, i_A} << w_amt;
    w_shr = {i_A, 1'b0} >> w_amt;
    alu_y_d = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (i_OP)
      OP_ADD: begin
        alu_y_d = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_v     = (i_A[MSB] == i_B[MSB]) && (w_sum[MSB] != i_A[MSB]);
      end
      OP_SUB: begin
        alu_y_d = w_dif[WIDTH-1:0];
        w_c     = w_dif[WIDTH];
        w_v     = (i_A[MSB] != i_B[MSB]) && (w_dif[MSB] != i_A[MSB]);
      end
      OP_AND: alu_y_d = i_A & i_B;
      OP_OR:  alu_y_d = i_A | i_B;
      OP_XOR: alu_y_d = i_A ^ i_B;
      OP_SLT: alu_y_d = {{(WIDTH-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
      OP_SHL: begin
        alu_y_d = w_shl[WIDTH-1:0];
        w_c     = w_shl[WIDTH];
      end
      OP_SHR: begin
        alu_y_d = w_shr[WIDTH:1];
        w_c     = w_shr[0];
      end
      default: alu_y_d = '0;
    endcase
    alu_flags_d = {w_c, w_v, alu_y_d[MSB], ~|alu_y_d};
  end

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  y_q     [STAGES];
  logic [3:0]        flags_q [STAGES];
  logic [STAGES:0]   w_rdy;

  // A stage can load when it is empty or its successor can load too, so
  // bubbles are squeezed out behind a stalled output.
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = i_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = ~vld_q[k] | w_rdy[k+1];
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k]     <= '0;
        flags_q[k] <= '0;
      end
    end else begin
      if (w_rdy[0]) begin
        vld_q[0]   <= i_VALID;
        y_q[0]     <= alu_y_d;
        flags_q[0] <= alu_flags_d;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          vld_q[k]   <= vld_q[k-1];
          y_q[k]     <= y_q[k-1];
          flags_q[k] <= flags_q[k-1];
        end
      end
    end
  end

  assign o_READY = w_rdy[0];
  assign o_VALID = vld_q[STAGES-1];
  assign o_Y     = y_q[STAGES-1];
  assign o_FLAGS = flags_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_pipe : vector table plus scoreboarded streaming checks for alu_pipe  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i_A = '0;
  logic [W-1:0] i_B = '0;
  logic [2:0]   i_OP = '0;
  logic         i_VALID = 1'b0;
  logic         i_READY = 1'b0;
  logic         o_READY;
  logic         o_VALID;
  logic [W-1:0] o_Y;
  logic [3:0]   o_FLAGS;

  alu_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .i_CLK(clk), .i_RST(rst), .i_A(i_A), .i_B(i_B), .i_OP(i_OP),
    .i_VALID(i_VALID), .o_READY(o_READY), .o_VALID(o_VALID),
    .i_READY(i_READY), .o_Y(o_Y), .o_FLAGS(o_FLAGS)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] y; logic [3:0] f;} vec_t;
  typedef struct {logic [3:0] y; logic [3:0] f; int cyc; bit exact;} sb_t;

  sb_t        q[$];
  vec_t       vt[16];
  int         n_chk = 0, n_fail = 0, cyc = 0, n_in = 0, n_out = 0, stall_cnt = 0;
  bit         exact_mode = 0, prev_stall = 0, saw_low = 0;
  logic [3:0] prev_y = '0, prev_f = '0, pend_y = '0, pend_f = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Independent integer reference for one operation: returns {Y, C, V, N, Z}.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa, sbv, r, amt;
    bit c = 0, v = 0;
    logic [3:0] y;
    sa  = (ua >= 8) ? ua - 16 : ua;
    sbv = (ub >= 8) ? ub - 16 : ub;
    amt = ub % 4;
    r   = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 15); v = ((sa + sbv) > 7) || ((sa + sbv) < -8); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = ((sa - sbv) > 7) || ((sa - sbv) < -8); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sbv) ? 1 : 0;
      3'd6: begin r = ua << amt; c = (((ua << amt) >> 4) & 1) != 0; end
      default: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
    endcase
    y = r[3:0];
    return {y, c, v, y[3], (y == 4'd0)};
  endfunction

  // One clock: check the cycle's outputs against the scoreboard, then advance.
  task automatic tick(output bit acc);
    sb_t e;
    #1;
    chk("o_READY", o_READY, ((q.size() < S) || i_READY));
    chk("spurious_valid", (o_VALID && (q.size() == 0)), 0);
    if (prev_stall) begin
      chk("stall_valid", o_VALID, 1);
      chk("stall_y", o_Y, prev_y);
      chk("stall_flags", o_FLAGS, prev_f);
    end
    if (o_VALID && i_READY && (q.size() != 0)) begin
      e = q.pop_front();
      chk("result_y", o_Y, e.y);
      chk("result_flags", o_FLAGS, e.f);
      if (e.exact) chk("latency", cyc - e.cyc, S);
      n_out++;
    end
    acc = i_VALID && o_READY;
    if (acc) begin
      e.y = pend_y; e.f = pend_f; e.cyc = cyc; e.exact = exact_mode;
      q.push_back(e);
      n_in++;
    end
    prev_stall = o_VALID && !i_READY;
    prev_y = o_Y;
    prev_f = o_FLAGS;
    if (!o_READY) saw_low = 1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) i_READY = 1'b1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] y, input logic [3:0] f);
    bit acc = 0;
    i_VALID = 1'b1; i_OP = op; i_A = a; i_B = b; pend_y = y; pend_f = f;
    for (int t = 0; t < 100 && !acc; t++) tick(acc);
    if (!acc) chk("send_timeout", 0, 1);
    i_VALID = 1'b0;
  endtask

  task automatic drain();
    bit a;
    i_VALID = 1'b0;
    i_READY = 1'b1;
    for (int t = 0; t < 50 && q.size() != 0; t++) tick(a);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    logic [7:0] m;
    int         c0;

    vt[0]  = '{3'd0, 4'h7, 4'h9, 4'h0, 4'b1001};
    vt[1]  = '{3'd1, 4'h3, 4'h5, 4'hE, 4'b1010};
    vt[2]  = '{3'd0, 4'h7, 4'h1, 4'h8, 4'b0110};
    vt[3]  = '{3'd5, 4'h8, 4'h1, 4'h1, 4'b0000};
    vt[4]  = '{3'd6, 4'hB, 4'h1, 4'h6, 4'b1000};
    vt[5]  = '{3'd7, 4'h1, 4'h1, 4'h0, 4'b1001};
    vt[6]  = '{3'd6, 4'hB, 4'h0, 4'hB, 4'b0010};
    vt[7]  = '{3'd2, 4'hC, 4'hA, 4'h8, 4'b0010};
    vt[8]  = '{3'd3, 4'h0, 4'h0, 4'h0, 4'b0001};
    vt[9]  = '{3'd4, 4'hF, 4'hF, 4'h0, 4'b0001};
    vt[10] = '{3'd4, 4'h5, 4'hA, 4'hF, 4'b0010};
    vt[11] = '{3'd1, 4'h8, 4'h1, 4'h7, 4'b0100};
    vt[12] = '{3'd7, 4'h8, 4'h3, 4'h1, 4'b0000};
    vt[13] = '{3'd6, 4'h1, 4'h7, 4'h8, 4'b0010};
    vt[14] = '{3'd5, 4'h1, 4'h8, 4'h0, 4'b0001};
    vt[15] = '{3'd0, 4'hF, 4'h1, 4'h0, 4'b1001};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_VALID, 0);
    chk("rst_y", o_Y, 0);
    chk("rst_flags", o_FLAGS, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", o_READY, 1);
    @(negedge clk);

    // ADD 7+9 latency and result
    exact_mode = 1;
    i_READY = 1'b1;
    i_VALID = 1'b1; i_OP = 3'd0; i_A = 4'h7; i_B = 4'h9; pend_y = 4'h0; pend_f = 4'b1001;
    tick(acc);
    i_VALID = 1'b0;
    chk("t1_accept", acc, 1);
    #1;
    chk("t1_valid_cycle1", o_VALID, 0);
    tick(acc);
    #1;
    chk("t1_valid_cycle2", o_VALID, 1);
    chk("t1_y", o_Y, 4'h0);
    chk("t1_flags", o_FLAGS, 4'b1001);
    drain();

    // Vector table, back-to-back
    foreach (vt[i]) send(vt[i].op, vt[i].a, vt[i].b, vt[i].y, vt[i].f);
    drain();

    // Ops 0..7 streamed with a 5-cycle output stall
    exact_mode = 0;
    saw_low = 0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (i == 3) begin
        i_READY = 1'b0;
        stall_cnt = 5;
      end
      m = model(3'(i), ra, rb);
      send(3'(i), ra, rb, m[7:4], m[3:0]);
    end
    drain();
    chk("t4_backpressure_seen", saw_low, 1);

    // Random valid/ready against the reference model
    n_in = 0; n_out = 0; acc = 0;
    i_VALID = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!i_VALID || acc) begin
        i_VALID = ($urandom_range(0, 1) != 0);
        i_OP = 3'($urandom_range(0, 7));
        i_A  = 4'($urandom_range(0, 15));
        i_B  = 4'($urandom_range(0, 15));
        m = model(i_OP, i_A, i_B);
        pend_y = m[7:4]; pend_f = m[3:0];
      end
      i_READY = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    drain();
    chk("t5_count", n_out, n_in);

    // Full-rate throughput with the consumer always ready
    exact_mode = 1;
    i_READY = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      logic [2:0] rop;
      logic [3:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      m = model(rop, ra, rb);
      send(rop, ra, rb, m[7:4], m[3:0]);
    end
    chk("t5_throughput_cycles", cyc - c0, 20);
    drain();
    exact_mode = 0;

    // Asynchronous reset with two results in flight
    i_READY = 1'b0;
    m = model(3'd0, 4'h3, 4'h4);
    send(3'd0, 4'h3, 4'h4, m[7:4], m[3:0]);
    m = model(3'd4, 4'h9, 4'h6);
    send(3'd4, 4'h9, 4'h6, m[7:4], m[3:0]);
    tick(acc);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", o_VALID, 0);
    chk("t6_y", o_Y, 0);
    chk("t6_flags", o_FLAGS, 0);
    q.delete();
    prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    i_READY = 1'b1;
    #1;
    chk("t6_ready", o_READY, 1);
    for (int t = 0; t < 6; t++) tick(acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
